// File: rtl/transpose_output_collector_pkg.sv
// ----------------------------------------------------------------------------
// transpose_pkg
// Shared definitions for the transposed-convolution output collector:
//   SHIFT_W          width of the output rounding-shift control
//   CALC_W / calc_t  wide signed working type used by the output arithmetic
//   calc_cidw()      column-ID width for a given number of columns
//   round_shift_sat() round-half-up arithmetic shift followed by saturation
// ----------------------------------------------------------------------------
package transpose_pkg;

  localparam int SHIFT_W = 4;

  // Working width for the output arithmetic. Partial sums up to 62 bits wide
  // can be sign-extended into it and rounded without wrapping.
  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // Column-ID width; a single bit is kept even for tiny arrays.
  function automatic int calc_cidw(input int dim);
    return (dim <= 2) ? 1 : $clog2(dim);
  endfunction

  // x arrives sign-extended from its DW-bit source. For sh > 0 the rounding
  // bias 2^(sh-1) is added before the arithmetic shift (round half up); the
  // wide working type means the biased sum never wraps. The result is clamped
  // to the signed ow-bit range and the caller keeps only the low ow bits.
  function automatic calc_t round_shift_sat(input calc_t x,
                                            input logic [SHIFT_W-1:0] sh,
                                            input int ow);
    calc_t rounded;
    calc_t shifted;
    calc_t max_v;
    calc_t min_v;
    calc_t y;
    max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (ow - 1));
    if (sh == 4'd0) begin
      rounded = x;
    end else begin
      rounded = x + (64'sd1 <<< (sh - 4'd1));
    end
    shifted = rounded >>> sh;
    if (shifted > max_v) begin
      y = max_v;
    end else if (shifted < min_v) begin
      y = min_v;
    end else begin
      y = shifted;
    end
    return y;
  endfunction

endpackage

// File: rtl/transpose_output_collector_if.sv
// ----------------------------------------------------------------------------
// transpose_output_collector_if
// Bundles the collector's data-path and handshake signals.
//   diag_in   packed diagonal partial sums, column k at [DW*(k+1)-1 : DW*k]
//   capture   per-column capture strobe
//   shift     rounding right-shift amount applied when a result is loaded
//   flush     synchronous clear of slots, flags, pointer and output register
//   out_*     valid/ready result port with column ID
//   pending   per-slot occupied flags
//   overflow  sticky per-column dropped-capture flags
//   busy      any slot pending or a result waiting
// Modports: master = array/control/consumer side, slave = collector.
// ----------------------------------------------------------------------------
interface transpose_output_collector_if
  import transpose_pkg::*;
#(
  parameter int DW        = 16,
  parameter int Dimension = 16,
  parameter int OW        = 16
);
  localparam int CIDW = calc_cidw(Dimension);

  logic [DW*Dimension-1:0] diag_in;
  logic [Dimension-1:0]    capture;
  logic [SHIFT_W-1:0]      shift;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OW-1:0]    out_data;
  logic [CIDW-1:0]         out_col;
  logic [Dimension-1:0]    pending;
  logic [Dimension-1:0]    overflow;
  logic                    busy;

  modport master (
    output diag_in, capture, shift, flush, out_ready,
    input  out_valid, out_data, out_col, pending, overflow, busy
  );

  modport slave (
    input  diag_in, capture, shift, flush, out_ready,
    output out_valid, out_data, out_col, pending, overflow, busy
  );

endinterface

// File: rtl/transpose_output_collector_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: grants the first set request at or
// after ptr_i, wrapping modulo N.
//   req_i        request vector
//   ptr_i        search start index (always < N)
//   grant_o      one-hot grant
//   idx_o        index of the granted request
//   any_grant_o  at least one request was set
// ----------------------------------------------------------------------------
module rr_arbiter
  import transpose_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]               req_i,
  input  logic [calc_cidw(N)-1:0]    ptr_i,
  output logic [N-1:0]               grant_o,
  output logic [calc_cidw(N)-1:0]    idx_o,
  output logic                       any_grant_o
);
  localparam int IW = calc_cidw(N);
  localparam logic [IW:0] N_W = (IW+1)'(N);

  // scan N candidates starting at ptr_i; the first hit masks all later ones
  always_comb begin
    logic [IW:0] cand;
    logic        hit;
    grant_o     = '0;
    idx_o       = '0;
    any_grant_o = 1'b0;
    cand        = '0;
    hit         = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(i);
      // one conditional subtract is enough because ptr_i < N and i < N
      cand = (cand >= N_W) ? (cand - N_W) : cand;
      hit  = req_i[cand[IW-1:0]] & ~any_grant_o;
      grant_o[cand[IW-1:0]] = grant_o[cand[IW-1:0]] | hit;
      idx_o       = hit ? cand[IW-1:0] : idx_o;
      any_grant_o = any_grant_o | hit;
    end
  end

endmodule

// File: rtl/transpose_output_collector.sv
// ----------------------------------------------------------------------------
// transpose_output_collector
// Captures each diagonal PE partial sum into a per-column holding slot on its
// capture strobe, then drains pending slots round-robin through a registered
// valid/ready port with rounding shift and saturation applied on load.
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   col_if  slave modport of transpose_output_collector_if (see that file)
// ----------------------------------------------------------------------------
module transpose_output_collector
  import transpose_pkg::*;
#(
  parameter int DW        = 16,
  parameter int Dimension = 16,
  parameter int OW        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  transpose_output_collector_if.slave   col_if
);
  localparam int CIDW = calc_cidw(Dimension);
  localparam logic [CIDW-1:0] LAST_COL = CIDW'(Dimension - 1);
  localparam logic [CIDW-1:0] ONE_COL  = CIDW'(32'd1);

  logic signed [DW-1:0] slot_q [Dimension];
  logic [Dimension-1:0] pending_q, pending_d;
  logic [Dimension-1:0] overflow_q, overflow_d;
  logic [CIDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [OW-1:0] out_data_q, out_data_d;
  logic [CIDW-1:0]      out_col_q, out_col_d;

  logic [Dimension-1:0] grant_s;
  logic [Dimension-1:0] granted_s;
  logic [Dimension-1:0] accept_s;
  logic [Dimension-1:0] drop_s;
  logic [Dimension-1:0] slot_we_s;
  logic [CIDW-1:0]      grant_idx_s;
  logic                 any_grant_s;
  logic                 out_free_s;
  logic                 load_s;
  logic signed [DW-1:0] grant_val_s;

  rr_arbiter #(.N(Dimension)) u_arb (
    .req_i       (pending_q),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant_s),
    .idx_o       (grant_idx_s),
    .any_grant_o (any_grant_s)
  );

  // next state for slot flags, round-robin pointer and output register
  always_comb begin
    out_free_s  = ~out_valid_q | col_if.out_ready;
    load_s      = out_free_s & any_grant_s;
    granted_s   = load_s ? grant_s : '0;
    // a slot being drained this cycle may take a new capture in the same edge
    accept_s    = col_if.capture & (~pending_q | granted_s);
    drop_s      = col_if.capture & pending_q & ~granted_s;
    grant_val_s = slot_q[grant_idx_s];

    pending_d   = (pending_q & ~granted_s) | accept_s;
    overflow_d  = overflow_q | drop_s;
    slot_we_s   = accept_s;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;

    if (col_if.flush) begin
      // flush overrides captures and any load in the same cycle
      pending_d   = '0;
      overflow_d  = '0;
      slot_we_s   = '0;
      rr_ptr_d    = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_col_d   = '0;
    end else if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = OW'(round_shift_sat(calc_t'(grant_val_s), col_if.shift, OW));
      out_col_d   = grant_idx_s;
      rr_ptr_d    = (grant_idx_s == LAST_COL) ? '0 : (grant_idx_s + ONE_COL);
    end else if (col_if.out_ready) begin
      // result consumed (or none held) and nothing pending to replace it
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      overflow_q  <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
    end
  end

  // per-column holding slots, written only when a capture is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < Dimension; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < Dimension; k++) begin
        if (slot_we_s[k]) begin
          slot_q[k] <= col_if.diag_in[DW*k +: DW];
        end
      end
    end
  end

  assign col_if.out_valid = out_valid_q;
  assign col_if.out_data  = out_data_q;
  assign col_if.out_col   = out_col_q;
  assign col_if.pending   = pending_q;
  assign col_if.overflow  = overflow_q;
  assign col_if.busy      = (|pending_q) | out_valid_q;

endmodule

// File: doc/transpose_output_collector.md
# transpose_output_collector

Parametrised output stage for the transposed-convolution compute engine; replaces the fixed 16-to-1 diagonal mux and delayed-valid path. Captures each diagonal PE partial sum into a per-column holding slot when that column's output enable fires, then drains pending slots round-robin through a valid/ready port. Each result carries its column ID and passes through a registered rounding-shift/saturate stage. Sits between the systolic array's diagonal outputs and the accumulation unit.

## Interface
- DW, 16, partial-sum width of each diagonal PE output (signed).
- Dimension, 16, number of array columns and slots; must be ≥ 2, need not be a power of two.
- OW, 16, output data width (signed); must satisfy OW ≤ DW.
- CIDW, derived as max(1, clog2(Dimension)), column-ID width; local, not overridable.
- Clocking: one clock; reset is asynchronous and active-high. The clock port is named clk and the reset port is named rst.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- diag_in  in  DW*Dimension  packed diagonal partial sums; column k occupies bits [DW*(k+1)-1 : DW*k].
- capture  in  Dimension  one-cycle strobe per column (driven by control's en_output); bit k latches the slice for column k.
- shift  in  4  arithmetic right-shift amount (0–15) applied at output load; quasi-static, sampled at load.
- flush  in  1  synchronous clear of all slots and the output register.
- out_valid  out  1  out_data/out_col are valid.
- out_ready  in  1  consumer accepts the current result.
- out_data  out  OW  rounded, shifted, saturated result.
- out_col  out  CIDW  column index of out_data.
- pending  out  Dimension  per-slot occupied flags.
- overflow  out  Dimension  sticky per-column dropped-capture flags.
- busy  out  1  OR of pending and out_valid.

## Operation
- Slot k holds a DW-bit value plus a pending bit.
- On capture[k]:
  - Slot empty, or slot granted this cycle: store diag_in slice k and set pending[k].
  - Slot pending and not granted this cycle: drop the new value, keep the old one, and set overflow[k].
- Output register loads when it is empty or is being consumed this cycle (out_valid & out_ready).
  - The round-robin arbiter grants the first pending slot at or after rr_ptr, wrapping modulo Dimension.
  - Granted slot: pending cleared; rr_ptr set to grant+1, with Dimension-1 wrapping to 0.
  - No pending slot: no load; out_valid drops if the current result was consumed.
- Arithmetic at load, on signed value x:
  - shift = 0: y = x.
  - shift > 0: y = (x + 2^(shift-1)) >>> shift, computed in DW+1 bits (round half up, no wrap).
  - y is saturated to the signed OW range [-2^(OW-1), 2^(OW-1)-1].
  - out_col receives the granted index.
- out_data and out_col hold stable while out_valid=1 and out_ready=0.
- flush:
  - Clears pending, out_valid, overflow and rr_ptr.
  - Wins over capture and load in the same cycle; captures in that cycle are discarded.

## Timing
- Reset: all outputs and state are 0, including pending, overflow, out_valid, out_data, out_col, busy and rr_ptr.
- capture at edge t: pending visible after t. With the output register free, out_valid=1 after edge t+1 (2-cycle latency).
- Back-to-back throughput: one result per cycle while out_ready=1 and any slot is pending.
- Simultaneous captures on several columns in one cycle are all accepted; they drain in round-robin order starting at rr_ptr.
- out_ready while out_valid=0 is ignored.
- Reset mid-stream: all pending data is lost immediately (asynchronous).

## Structure
- Shared package transpose_pkg holds:
  - the CIDW computation function;
  - a round_shift_sat function (DW in, OW out, 4-bit shift);
  - the localparam for the shift width (4).
- One sub-module, rr_arbiter #(N): pending vector plus pointer in, one-hot grant, index and any_grant out; purely combinational.
- Slot storage, pointer, output register and sticky flags live in transpose_output_collector.

## Test plan
- Single capture: capture=16'h0004 with slice 2 = 100, shift=0, out_ready=1 -> out_valid two cycles later with out_data=100 and out_col=2, then pending=0.
- Multi-capture round-robin: capture=16'hFFFF with slice k = k, out_ready=1 -> out_col 0..15 in order on 16 consecutive cycles, busy falls after the last.
- Backpressure and overflow: capture col 5 (=7), out_ready=0, then capture col 5 (=9) twice -> out_data=7 held, overflow[5]=1, slot keeps its value; with pending[5] still 1 after the first drain, out_ready=1 later yields 7 then 9.
- Rounding and saturation (DW=16, OW=8): x=300, shift=2 -> 75; x=301, shift=1 -> 127 (saturated); x=-6, shift=2 -> -1; x=-32768, shift=0 -> -128.
- Grant/capture collision: slot 3 granted in the same cycle capture[3] brings 55 -> overflow stays 0, and 55 is emitted next.
- Flush and reset: flush asserted with 4 slots pending and capture=16'h0001 -> next cycle pending=0, out_valid=0, overflow=0. rst asserted mid-drain -> all outputs 0 immediately.
